spi_arbiter: RTL and testbench

Round-robin controller that shares one SPI_Core between up to N_REQ requesters. It grants the core to one requester at a time and drives the core's write/instr/data_reg/ss_n inputs. For each granted transaction it asserts the chosen slave select, streams len+1 bytes through the core, and returns each received byte to the granted requester. Sits between the system-side requesters and the SPI_Core instance.

---
 rtl/spi_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/spi_arbiter.sv | 174 +++++++++++++++++
 tb/tb_spi_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI_Core round-robin arbiter.
package spi_pkg;

    localparam logic [1:0] INSTR_XFER       = 2'b00;
    localparam logic [1:0] INSTR_SS_ASSERT  = 2'b01;
    localparam logic [1:0] INSTR_SS_RELEASE = 2'b10;
    localparam logic [1:0] INSTR_CFG        = 2'b11;

    localparam int DEFAULT_TIMEOUT = 4096;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        SS_ON,
        ISSUE,
        WAIT,
        SS_OFF
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IW-1:0]    idx_o,
    output logic             valid_o
);

    logic found;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            int j;
            j = (int'(ptr_i) + i) % N_REQ;
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IW'(j);
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin sharing of one SPI_Core: SS assert, len+1 byte transfers, SS release per grant.
// Define SPI_ARB_TIMEOUT_EN to abort a transaction after TIMEOUT cycles without spi_done.
module spi_arbiter
    import spi_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int S       = 4,
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*$clog2(S)-1:0] req_ss,
    input  logic [N_REQ*LEN_W-1:0]     req_len,
    input  logic [N_REQ*8-1:0]         tx_data,
    output logic [N_REQ-1:0]           gnt,
    output logic                       byte_ack,
    output logic [7:0]                 rx_data,
    output logic                       rx_valid,
    output logic [N_REQ-1:0]           done,
    output logic                       err,
    output logic                       busy,
    output logic                       spi_write,
    output logic [1:0]                 spi_instr,
    output logic [7:0]                 spi_data,
    output logic [S-1:0]               spi_ss_n,
    input  logic                       spi_done,
    input  logic [7:0]                 spi_out
);

    localparam int IW  = $clog2(N_REQ);
    localparam int SSW = $clog2(S);

    arb_state_e       state_q;
    logic [IW-1:0]    rr_ptr_q, idx_q;
    logic [SSW-1:0]   ss_q;
    logic [LEN_W-1:0] len_q, cnt_q;
    logic [N_REQ-1:0] gnt_q, done_q;
    logic             busy_q, byte_ack_q, rx_valid_q, spi_write_q;
    logic [7:0]       rx_data_q, spi_data_q;
    logic [1:0]       spi_instr_q;
    logic [S-1:0]     spi_ss_n_q;

    logic [N_REQ-1:0] pick_gnt;
    logic [IW-1:0]    pick_idx;
    logic             pick_valid;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q;
    logic          err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_rr (
        .req_i   (req),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            idx_q       <= '0;
            ss_q        <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            busy_q      <= 1'b0;
            byte_ack_q  <= 1'b0;
            rx_valid_q  <= 1'b0;
            rx_data_q   <= '0;
            spi_write_q <= 1'b0;
            spi_instr_q <= INSTR_XFER;
            spi_data_q  <= '0;
            spi_ss_n_q  <= '1;
`ifdef SPI_ARB_TIMEOUT_EN
            tmo_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments only; pulses default low each cycle.
            spi_write_q <= 1'b0;
            byte_ack_q  <= 1'b0;
            rx_valid_q  <= 1'b0;
            done_q      <= '0;
            case (state_q)
                IDLE: begin
                    gnt_q  <= '0;
                    busy_q <= 1'b0;
                    if (pick_valid) begin
                        idx_q   <= pick_idx;
                        ss_q    <= req_ss[pick_idx*SSW +: SSW];
                        len_q   <= req_len[pick_idx*LEN_W +: LEN_W];
                        cnt_q   <= '0;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    gnt_q   <= N_REQ'(1) << idx_q;
                    busy_q  <= 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
                    err_q   <= 1'b0;
`endif
                    state_q <= SS_ON;
                end
                SS_ON: begin
                    spi_ss_n_q  <= ~(S'(1) << ss_q);
                    spi_write_q <= 1'b1;
                    spi_instr_q <= INSTR_SS_ASSERT;
                    state_q     <= ISSUE;
                end
                ISSUE: begin
                    spi_data_q  <= tx_data[idx_q*8 +: 8];
                    spi_instr_q <= INSTR_XFER;
                    spi_write_q <= 1'b1;
                    byte_ack_q  <= 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
                    tmo_q       <= '0;
`endif
                    state_q     <= WAIT;
                end
                WAIT: begin
                    if (spi_done) begin
                        rx_data_q  <= spi_out;
                        rx_valid_q <= 1'b1;
                        if (cnt_q == len_q) begin
                            state_q <= SS_OFF;
                        end else begin
                            cnt_q   <= cnt_q + 1'b1;
                            state_q <= ISSUE;
                        end
                    end
`ifdef SPI_ARB_TIMEOUT_EN
                    else if (tmo_q == TW'(TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        state_q <= SS_OFF;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
`endif
                end
                SS_OFF: begin
                    spi_write_q <= 1'b1;
                    spi_instr_q <= INSTR_SS_RELEASE;
                    spi_ss_n_q  <= '1;
                    done_q      <= gnt_q;
                    rr_ptr_q    <= (idx_q == IW'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign byte_ack  = byte_ack_q;
    assign rx_valid  = rx_valid_q;
    assign rx_data   = rx_data_q;
    assign spi_write = spi_write_q;
    assign spi_instr = spi_instr_q;
    assign spi_data  = spi_data_q;
    assign spi_ss_n  = spi_ss_n_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Scoreboard bench for spi_arbiter with a loopback SPI_Core model; SPI_ARB_TIMEOUT_EN adds the abort case.
module tb_spi_arbiter;
    import spi_pkg::*;

    typedef enum logic [1:0] {EV_ACK, EV_RX, EV_DONE} ev_e;
    typedef struct {
        ev_e        kind;
        logic [3:0] mask;
        logic [7:0] data;
        logic [3:0] ss_n;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req;
    logic [7:0]  req_ss;
    logic [15:0] req_len;
    logic [31:0] tx_data;
    logic [3:0]  gnt, done;
    logic        byte_ack, rx_valid, err, busy, spi_write;
    logic [7:0]  rx_data, spi_data, spi_out, core_out, stray_out;
    logic [1:0]  spi_instr;
    logic [3:0]  spi_ss_n;
    logic        spi_done, core_done, stray_done;
    logic        core_en = 1'b1;
    logic        sb_en = 1'b1;

    exp_t exp_q[$];
    int   n_checks = 0, n_err = 0;
    int   n_ack = 0, n_rx = 0, n_done = 0, n_assert = 0, n_release = 0;

    assign spi_done = core_done | stray_done;
    assign spi_out  = stray_done ? stray_out : core_out;

    always #5 clk = ~clk;

    spi_arbiter #(.N_REQ(4), .S(4), .LEN_W(4), .TIMEOUT(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_ss    (req_ss),
        .req_len   (req_len),
        .tx_data   (tx_data),
        .gnt       (gnt),
        .byte_ack  (byte_ack),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .done      (done),
        .err       (err),
        .busy      (busy),
        .spi_write (spi_write),
        .spi_instr (spi_instr),
        .spi_data  (spi_data),
        .spi_ss_n  (spi_ss_n),
        .spi_done  (spi_done),
        .spi_out   (spi_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic expire(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic push(input ev_e k, input logic [3:0] m, input logic [7:0] d, input logic [3:0] s);
        exp_q.push_back('{kind: k, mask: m, data: d, ss_n: s});
    endtask

    task automatic sb_pop(input ev_e k, input logic [3:0] m, input logic [7:0] d, input logic [3:0] s);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL sb_unexpected: got %s event, expected none", k.name());
            return;
        end
        e = exp_q.pop_front();
        check("sb_kind", 32'(k), 32'(e.kind));
        check("sb_mask", 32'(m), 32'(e.mask));
        if (k != EV_DONE) check("sb_data", 32'(d), 32'(e.data));
        if (k == EV_ACK)  check("sb_ss_n", 32'(s), 32'(e.ss_n));
    endtask

    // sel 0 waits for byte_ack, sel 1 for any done pulse; returns on the observing negedge
    task automatic wait_ev(input string name, input bit sel);
        int c = 0;
        @(negedge clk);
        while (((sel ? |done : byte_ack) == 1'b0) && c < 2000) begin
            @(negedge clk);
            c++;
        end
        if ((sel ? |done : byte_ack) == 1'b0) expire(name);
    endtask

    task automatic set_req(input int i, input logic [1:0] ss, input logic [3:0] len, input logic [7:0] tx);
        req_ss[i*2 +: 2]  = ss;
        req_len[i*4 +: 4] = len;
        tx_data[i*8 +: 8] = tx;
    endtask

    // Loopback core: answers each XFER strobe three cycles later with the byte it was sent.
    initial begin
        logic [7:0] d;
        core_done = 1'b0;
        core_out  = '0;
        forever begin
            @(negedge clk);
            if (core_en && spi_write && spi_instr == INSTR_XFER) begin
                d = spi_data;
                repeat (3) @(negedge clk);
                core_out  = d;
                core_done = 1'b1;
                @(negedge clk);
                core_done = 1'b0;
            end
        end
    end

    // Monitor: counts strobes, advances requester tx bytes on ack, checks pulses against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (spi_write && spi_instr == INSTR_SS_ASSERT)  n_assert++;
            if (spi_write && spi_instr == INSTR_SS_RELEASE) n_release++;
            if (byte_ack) begin
                n_ack++;
                if (sb_en) sb_pop(EV_ACK, gnt, spi_data, spi_ss_n);
                for (int i = 0; i < 4; i++)
                    if (gnt[i]) tx_data[i*8 +: 8] = tx_data[i*8 +: 8] + 8'h11;
            end
            if (rx_valid) begin
                n_rx++;
                if (sb_en) sb_pop(EV_RX, gnt, rx_data, 4'hF);
            end
            if (|done) begin
                n_done++;
                if (sb_en) sb_pop(EV_DONE, done, 8'h00, 4'hF);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] fair_bytes [8] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
        logic [3:0] fair_ssn   [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        int c_ack, c_rx, c_as, c_rl, c_d;

        req = '0; req_ss = '0; req_len = '0; tx_data = '0;
        stray_done = 1'b0; stray_out = '0;

        repeat (3) @(negedge clk);
        check("rst_gnt",       32'(gnt), 32'h0);
        check("rst_busy",      32'(busy), 32'h0);
        check("rst_spi_write", 32'(spi_write), 32'h0);
        check("rst_spi_instr", 32'(spi_instr), 32'(INSTR_XFER));
        check("rst_spi_data",  32'(spi_data), 32'h0);
        check("rst_spi_ss_n",  32'(spi_ss_n), 32'hF);
        check("rst_rx",        32'({rx_valid, rx_data}), 32'h0);
        check("rst_ack_done",  32'({byte_ack, done}), 32'h0);
        check("rst_err",       32'(err), 32'h0);
        rst = 1'b1;
        @(negedge clk);

        // single byte to slave 2
        set_req(0, 2'd2, 4'd0, 8'hB6);
        push(EV_ACK, 4'b0001, 8'hB6, 4'b1011);
        push(EV_RX, 4'b0001, 8'hB6, 4'hF);
        push(EV_DONE, 4'b0001, 8'h00, 4'hF);
        req[0] = 1'b1;
        @(negedge clk); check("lat_edge0_gnt", 32'(gnt), 32'h0);
        @(negedge clk); check("lat_edge1_gnt", 32'({busy, gnt}), 32'h11);
        @(negedge clk); check("lat_edge2_ss", 32'({spi_write, spi_instr, spi_ss_n}), 32'({1'b1, INSTR_SS_ASSERT, 4'b1011}));
        @(negedge clk); check("lat_edge3_xfer", 32'({spi_write, spi_instr, spi_data}), 32'({1'b1, INSTR_XFER, 8'hB6}));
        wait_ev("single_done", 1'b1);
        req = '0;
        check("single_release", 32'({spi_write, spi_instr, spi_ss_n}), 32'({1'b1, INSTR_SS_RELEASE, 4'hF}));
        @(negedge clk);
        check("single_busy_off", 32'({busy, gnt}), 32'h0);
        check("single_sb_empty", 32'(exp_q.size()), 32'h0);

        // stray spi_done while idle
        c_rx = n_rx;
        stray_out = 8'hEE;
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        repeat (3) @(negedge clk);
        check("stray_done_ignored", 32'(n_rx - c_rx), 32'h0);

        // four bytes to slave 1
        c_ack = n_ack; c_rx = n_rx; c_as = n_assert; c_rl = n_release;
        set_req(2, 2'd1, 4'd3, 8'h30);
        push(EV_ACK, 4'b0100, 8'h30, 4'b1101); push(EV_RX, 4'b0100, 8'h30, 4'hF);
        push(EV_ACK, 4'b0100, 8'h41, 4'b1101); push(EV_RX, 4'b0100, 8'h41, 4'hF);
        push(EV_ACK, 4'b0100, 8'h52, 4'b1101); push(EV_RX, 4'b0100, 8'h52, 4'hF);
        push(EV_ACK, 4'b0100, 8'h63, 4'b1101); push(EV_RX, 4'b0100, 8'h63, 4'hF);
        push(EV_DONE, 4'b0100, 8'h00, 4'hF);
        req[2] = 1'b1;
        wait_ev("multi_done", 1'b1);
        req = '0;
        @(negedge clk);
        check("multi_acks",     32'(n_ack - c_ack), 32'd4);
        check("multi_rx",       32'(n_rx - c_rx), 32'd4);
        check("multi_asserts",  32'(n_assert - c_as), 32'd1);
        check("multi_releases", 32'(n_release - c_rl), 32'd1);
        check("multi_sb_empty", 32'(exp_q.size()), 32'h0);

        // fairness from a fresh rr_ptr
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) set_req(i, 2'(i), 4'd0, fair_bytes[i]);
        for (int k = 0; k < 8; k++) begin
            push(EV_ACK, 4'(1 << (k % 4)), fair_bytes[k], fair_ssn[k % 4]);
            push(EV_RX, 4'(1 << (k % 4)), fair_bytes[k], 4'hF);
            push(EV_DONE, 4'(1 << (k % 4)), 8'h00, 4'hF);
        end
        req = 4'b1111;
        for (int k = 0; k < 8; k++) wait_ev("fair_done", 1'b1);
        req = '0;
        @(negedge clk);
        check("fair_sb_empty", 32'(exp_q.size()), 32'h0);

        // requester 1 drops req after its first byte
        set_req(1, 2'd3, 4'd2, 8'h5C);
        push(EV_ACK, 4'b0010, 8'h5C, 4'b0111); push(EV_RX, 4'b0010, 8'h5C, 4'hF);
        push(EV_ACK, 4'b0010, 8'h6D, 4'b0111); push(EV_RX, 4'b0010, 8'h6D, 4'hF);
        push(EV_ACK, 4'b0010, 8'h7E, 4'b0111); push(EV_RX, 4'b0010, 8'h7E, 4'hF);
        push(EV_DONE, 4'b0010, 8'h00, 4'hF);
        req[1] = 1'b1;
        wait_ev("drop_first_ack", 1'b0);
        req[1] = 1'b0;
        wait_ev("drop_done", 1'b1);
        @(negedge clk);
        check("drop_sb_empty", 32'(exp_q.size()), 32'h0);

        // reset while waiting on the second byte
        sb_en = 1'b0;
        set_req(3, 2'd0, 4'd3, 8'h77);
        req[3] = 1'b1;
        wait_ev("rst_ack1", 1'b0);
        wait_ev("rst_ack2", 1'b0);
        #2 rst = 1'b0;
        #1;
        check("rst_mid_gnt",  32'(gnt), 32'h0);
        check("rst_mid_ss_n", 32'(spi_ss_n), 32'hF);
        check("rst_mid_busy", 32'({busy, spi_write}), 32'h0);
        c_d = n_done;
        req = '0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        check("rst_mid_no_done", 32'(n_done - c_d), 32'h0);
        exp_q.delete();
        sb_en = 1'b1;
        set_req(1, 2'd1, 4'd0, 8'hC4);
        set_req(3, 2'd0, 4'd0, 8'h99);
        push(EV_ACK, 4'b0010, 8'hC4, 4'b1101);
        push(EV_RX, 4'b0010, 8'hC4, 4'hF);
        push(EV_DONE, 4'b0010, 8'h00, 4'hF);
        req = 4'b1010;
        wait_ev("post_rst_done", 1'b1);
        req = '0;
        @(negedge clk);
        check("post_rst_sb_empty", 32'(exp_q.size()), 32'h0);

`ifdef SPI_ARB_TIMEOUT_EN
        // core never answers: abort after 16 WAIT cycles
        core_en = 1'b0;
        set_req(0, 2'd0, 4'd1, 8'h10);
        push(EV_ACK, 4'b0001, 8'h10, 4'b1110);
        push(EV_DONE, 4'b0001, 8'h00, 4'hF);
        req[0] = 1'b1;
        wait_ev("tmo_done", 1'b1);
        req = '0;
        check("tmo_release", 32'({spi_write, spi_instr, spi_ss_n}), 32'({1'b1, INSTR_SS_RELEASE, 4'hF}));
        @(negedge clk);
        check("tmo_err_set", 32'(err), 32'h1);
        core_en = 1'b1;
        set_req(0, 2'd0, 4'd0, 8'h20);
        push(EV_ACK, 4'b0001, 8'h20, 4'b1110);
        push(EV_RX, 4'b0001, 8'h20, 4'hF);
        push(EV_DONE, 4'b0001, 8'h00, 4'hF);
        req[0] = 1'b1;
        wait_ev("tmo_regrant_done", 1'b1);
        req = '0;
        check("tmo_err_cleared", 32'(err), 32'h0);
        @(negedge clk);
        check("tmo_sb_empty", 32'(exp_q.size()), 32'h0);
`endif

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
